// File: rtl/cipher_seq_ctrl.sv
// cipher_seq_ctrl: load/readout sequencer for an external byte-chaining cipher datapath.
// Optional CIPHER_SEQ_TIMEOUT_EN: abandon a readout after 255 stalled cycles and pulse err.
module cipher_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       start,
  input  logic       mode,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic [2:0] count,
  output logic       err,
  output logic [7:0] cph_ui,
  output logic       cph_encrypt,
  output logic       cph_inc,
  output logic       cph_view,
  output logic [1:0] cph_ct,
  input  logic [7:0] cph_out
);
  typedef enum logic [1:0] {IDLE, STEP, RSET, ROUT} state_t;
  state_t state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [1:0] idx_q, idx_d, ct_q, ct_d;
  logic [7:0] ui_q, ui_d, od_q, od_d;
  logic in_ready_q, in_ready_d, ov_q, ov_d, busy_q, busy_d, err_q, err_d;
  logic enc_q, enc_d, inc_q, inc_d, view_q, view_d;
`ifdef CIPHER_SEQ_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;
`endif
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    ct_d    = ct_q;
    ui_d    = ui_q;
    od_d    = od_q;
    ov_d    = ov_q;
    enc_d   = enc_q;
    view_d  = view_q;
    inc_d   = 1'b0;
    err_d   = 1'b0;
`ifdef CIPHER_SEQ_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        enc_d = 1'b0;
        // start outranks a simultaneous byte offer
        if (start && count_q != 3'd0) begin
          state_d = RSET;
          view_d  = mode;
          idx_d   = 2'(count_q - 3'd1);
          ct_d    = 2'(count_q - 3'd1);
        end else if (!start && in_valid && in_ready_q && count_q < 3'd4) begin
          state_d = STEP;
          ui_d    = in_data;
          enc_d   = 1'b1;
          inc_d   = 1'b1;
        end
      end
      STEP: begin
        state_d = IDLE;
        count_d = (count_q < 3'd4) ? count_q + 3'd1 : count_q;
      end
      RSET: begin
        state_d = ROUT;
        od_d    = cph_out;
        ov_d    = 1'b1;
`ifdef CIPHER_SEQ_TIMEOUT_EN
        tmo_d   = 8'd0;
`endif
      end
      default: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = (idx_q == 2'd0) ? IDLE : RSET;
          idx_d   = (idx_q == 2'd0) ? idx_q : idx_q - 2'd1;
          ct_d    = (idx_q == 2'd0) ? ct_q : idx_q - 2'd1;
        end
`ifdef CIPHER_SEQ_TIMEOUT_EN
        else if (tmo_q == 8'd254) begin
          ov_d    = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
    endcase
    in_ready_d = (state_d == IDLE) && (count_d < 3'd4);
    busy_d     = (state_d != IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= 3'd0;
      idx_q      <= 2'd0;
      ct_q       <= 2'd0;
      ui_q       <= 8'd0;
      od_q       <= 8'd0;
      ov_q       <= 1'b0;
      enc_q      <= 1'b0;
      inc_q      <= 1'b0;
      view_q     <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef CIPHER_SEQ_TIMEOUT_EN
      tmo_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      ct_q       <= ct_d;
      ui_q       <= ui_d;
      od_q       <= od_d;
      ov_q       <= ov_d;
      enc_q      <= enc_d;
      inc_q      <= inc_d;
      view_q     <= view_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
`ifdef CIPHER_SEQ_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end
  assign in_ready    = in_ready_q;
  assign out_data    = od_q;
  assign out_valid   = ov_q;
  assign busy        = busy_q;
  assign count       = count_q;
  assign err         = err_q;
  assign cph_ui      = ui_q;
  assign cph_encrypt = enc_q;
  assign cph_inc     = inc_q;
  assign cph_view    = view_q;
  assign cph_ct      = ct_q;
endmodule
